// File: rtl/mux_reg_8x8_if.sv
// mux_reg_8x8_if: write/read/scan signal bundle for the page register bank.
interface mux_reg_8x8_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic [WIDTH-1:0] in;
  logic [DEPTH-1:0] en_in;
  logic [DEPTH-1:0] en_out;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             td;
  logic             tq;
  modport master (output in, en_in, en_out, tc, td, input out, tq);
  modport slave  (input in, en_in, en_out, tc, td, output out, tq);
endinterface

// File: rtl/mux_reg_8x8.sv
// mux_reg_8x8: register bank with per-entry write enables, one-hot AND-OR read mux and full scan chain.
module mux_reg_8x8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  mux_reg_8x8_if.slave   bus
);
  localparam int N = WIDTH * DEPTH;
  logic [N-1:0]     q;
  logic [N-1:0]     q_wr;
  logic [WIDTH-1:0] o;
  for (genvar i = 0; i < DEPTH; i++) begin : g_wr
    assign q_wr[WIDTH*i +: WIDTH] = bus.en_in[i] ? bus.in : q[WIDTH*i +: WIDTH];
  end
  // scan chain runs from bit 0 (td) up to bit N-1 (tq)
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= bus.tc ? {q[N-2:0], bus.td} : q_wr;
  always_comb begin
    o = '0;
    for (int r = 0; r < DEPTH; r++) o = o | (q[WIDTH*r +: WIDTH] & {WIDTH{bus.en_out[r]}});
  end
  assign bus.out = o;
  assign bus.tq  = q[N-1];
endmodule

// File: tb/tb_mux_reg_8x8.sv
// tb_mux_reg_8x8: directed self-checking bench for mux_reg_8x8.
module tb_mux_reg_8x8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  mux_reg_8x8_if #(.WIDTH(8), .DEPTH(8)) bus ();
  mux_reg_8x8 #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] v;
    bus.in = '0; bus.en_in = '0; bus.en_out = '0; bus.tc = 1'b0; bus.td = 1'b0;
    step(); step();
    bus.en_out = 8'hFF;
    #1;
    chk("reset_out", bus.out, 8'h00);
    chk("reset_tq", {7'b0, bus.tq}, 8'h00);
    reset = 1'b0;
    bus.en_out = '0;
    // preload R[3], then assert reset mid-cycle
    bus.in = 8'hA5; bus.en_in = 8'h08;
    step();
    bus.en_in = '0; bus.en_out = 8'h08;
    #1;
    chk("preload_r3", bus.out, 8'hA5);
    reset = 1'b1;
    #1;
    chk("async_reset_out", bus.out, 8'h00);
    chk("async_reset_tq", {7'b0, bus.tq}, 8'h00);
    step();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      bus.in = 8'h10 + 8'(r); bus.en_in = 8'h01 << r;
      step();
    end
    bus.en_in = '0;
    for (int r = 0; r < 8; r++) begin
      bus.en_out = 8'h01 << r;
      #1;
      chk($sformatf("read_r%0d", r), bus.out, 8'h10 + 8'(r));
    end
    bus.en_out = '0;
    #1;
    chk("en_out_zero", bus.out, 8'h00);
    bus.in = 8'h3C; bus.en_in = 8'hFF;
    step();
    bus.en_in = '0; bus.en_out = 8'h81;
    #1;
    chk("broadcast_81", bus.out, 8'h3C);
    bus.in = 8'h01; bus.en_in = 8'h01;
    step();
    bus.in = 8'h80; bus.en_in = 8'h02;
    step();
    bus.en_in = '0; bus.en_out = 8'h03;
    #1;
    chk("multi_select_03", bus.out, 8'h81);
    bus.en_out = 8'h06;
    #1;
    chk("multi_select_06", bus.out, 8'hBC);
    bus.in = 8'h55; bus.en_in = 8'h04;
    step();
    bus.en_out = 8'h04; bus.in = 8'hAA; bus.en_in = 8'h04;
    #1;
    chk("same_cycle_before", bus.out, 8'h55);
    step();
    chk("same_cycle_after", bus.out, 8'hAA);
    bus.en_in = '0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.tc = 1'b1; bus.td = 1'b1;
    step();
    bus.td = 1'b0;
    for (int i = 0; i < 62; i++) step();
    chk("scan_tq_after63", {7'b0, bus.tq}, 8'h00);
    step();
    chk("scan_tq_after64", {7'b0, bus.tq}, 8'h01);
    bus.tc = 1'b0; bus.en_out = 8'h80;
    #1;
    chk("scan_bit63_out", bus.out, 8'h80);
    bus.en_out = 8'h7F;
    #1;
    chk("scan_rest_zero", bus.out, 8'h00);
    // shifting must ignore en_in; the lone set bit falls off the end
    bus.tc = 1'b1; bus.en_in = 8'hFF; bus.in = 8'h5A; bus.td = 1'b0;
    step();
    bus.en_out = 8'hFF;
    #1;
    chk("scan_ignores_en_in", bus.out, 8'h00);
    chk("scan_tq_cleared", {7'b0, bus.tq}, 8'h00);
    bus.tc = 1'b0;
    for (int r = 0; r < 8; r++) begin
      v = 8'(r);
      bus.in = v * 8'h11; bus.en_in = 8'h01 << r;
      step();
    end
    bus.en_in = '0;
    bus.tc = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.td = bus.tq;
      step();
    end
    bus.tc = 1'b0;
    for (int r = 0; r < 8; r++) begin
      v = 8'(r);
      bus.en_out = 8'h01 << r;
      #1;
      chk($sformatf("roundtrip_r%0d", r), bus.out, v * 8'h11);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
